// File: rtl/cc_pkg.sv
// Shared types, AXI R response codes and geometry helpers for the cache line-fill path.
package cc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } fill_state_t;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  localparam int unsigned DEF_DATA_W     = 64;
  localparam int unsigned DEF_LINE_BYTES = 64;
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_IDX_W      = 9;

  function automatic int unsigned beats_f(input int unsigned data_w, input int unsigned line_bytes);
    return (line_bytes * 8) / data_w;
  endfunction

  function automatic int unsigned off_w_f(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int unsigned tag_w_f(input int unsigned addr_w, input int unsigned idx_w,
                                          input int unsigned line_bytes);
    return addr_w - idx_w - $clog2(line_bytes);
  endfunction

  // Geometry of the default configuration
  localparam int unsigned BEATS = beats_f(DEF_DATA_W, DEF_LINE_BYTES);
  localparam int unsigned OFF_W = off_w_f(DEF_LINE_BYTES);
  localparam int unsigned TAG_W = tag_w_f(DEF_ADDR_W, DEF_IDX_W, DEF_LINE_BYTES);

endpackage

// File: rtl/cc_fill_deser.sv
// Line deserialiser: places R beats into slots (start+cnt) mod BEATS and captures the critical word.
module cc_fill_deser
  import cc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  localparam int unsigned N_BEATS   = beats_f(DATA_W, LINE_BYTES),
  localparam int unsigned CNT_W     = $clog2(N_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        start_slot_i,
  input  logic                    beat_vld_i,
  input  logic [DATA_W-1:0]       beat_data_i,
  output logic [CNT_W-1:0]        cnt_o,
  output logic [8*LINE_BYTES-1:0] line_o,
  output logic                    cw_valid_o,
  output logic [DATA_W-1:0]       cw_data_o
);

  logic [CNT_W-1:0]                start_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [N_BEATS-1:0][DATA_W-1:0]  line_q;
  logic [DATA_W-1:0]               cw_data_q;
  logic                            cw_valid_q;
  logic [CNT_W-1:0]                slot_c;

  // Slot pointer wraps naturally at BEATS
  assign slot_c = start_q + cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q    <= '0;
      cnt_q      <= '0;
      line_q     <= '0;
      cw_data_q  <= '0;
      cw_valid_q <= 1'b0;
    end else begin
      cw_valid_q <= 1'b0;
      if (start_i) begin
        start_q <= start_slot_i;
        cnt_q   <= '0;
      end else if (beat_vld_i) begin
        line_q[slot_c] <= beat_data_i;
        cnt_q          <= cnt_q + CNT_W'(1);
        if (cnt_q == '0) begin
          cw_data_q  <= beat_data_i;
          cw_valid_q <= 1'b1;
        end
      end
    end
  end

  assign cnt_o      = cnt_q;
  assign line_o     = line_q;
  assign cw_valid_o = cw_valid_q;
  assign cw_data_o  = cw_data_q;

endmodule

// File: rtl/cc_line_fill_unit.sv
// Cache line-fill engine: pops a miss, collects one R burst, then writes tag+line or flags an aborted fill.
module cc_line_fill_unit
  import cc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned IDX_W      = DEF_IDX_W,
  parameter int unsigned WRAP_MODE  = 1,
  localparam int unsigned LINE_OFF_W = off_w_f(LINE_BYTES),
  localparam int unsigned LINE_TAG_W = tag_w_f(ADDR_W, IDX_W, LINE_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  input  logic [1:0]              mem_rresp_i,
  input  logic                    mem_rlast_i,
  input  logic                    mem_rvalid_i,
  output logic                    mem_rready_o,
  input  logic                    miss_addr_fifo_empty_i,
  input  logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i,
  output logic                    miss_addr_fifo_rden_o,
  output logic                    wren_o,
  output logic [IDX_W-1:0]        waddr_o,
  output logic [LINE_TAG_W:0]     wdata_tag_o,
  output logic [8*LINE_BYTES-1:0] wdata_data_o,
  output logic                    cw_valid_o,
  output logic [DATA_W-1:0]       cw_data_o,
  output logic                    fill_err_o
);

  localparam int unsigned N_BEATS = beats_f(DATA_W, LINE_BYTES);
  localparam int unsigned CNT_W   = $clog2(N_BEATS);
  localparam int unsigned BYTE_W  = $clog2(DATA_W / 8);

  fill_state_t             state_q, state_d;
  logic                    err_q, err_d;
  logic                    rready_q, rready_d;
  logic                    wren_q, wren_d;
  logic                    ferr_q, ferr_d;
  logic [IDX_W-1:0]        waddr_q, waddr_d;
  logic [LINE_TAG_W:0]     tag_q, tag_d;
  logic                    pop_c;
  logic                    hs_c;
  logic                    last_beat_c;
  logic                    beat_err_c;
  logic [CNT_W-1:0]        cnt_c;
  logic [CNT_W-1:0]        start_slot_c;
  logic                    unused_addr_c;

  assign unused_addr_c = ^miss_addr_fifo_rdata_i[BYTE_W-1:0];

  assign start_slot_c = (WRAP_MODE != 0) ? miss_addr_fifo_rdata_i[BYTE_W +: CNT_W] : '0;
  assign hs_c         = mem_rvalid_i && rready_q;
  assign last_beat_c  = (cnt_c == CNT_W'(N_BEATS - 1));
  // RLAST must be set on exactly the final beat of the burst
  assign beat_err_c   = (mem_rresp_i == RRESP_SLVERR) || (mem_rresp_i == RRESP_DECERR) ||
                        (mem_rlast_i != last_beat_c);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    wren_d  = 1'b0;
    ferr_d  = 1'b0;
    waddr_d = waddr_q;
    tag_d   = tag_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!miss_addr_fifo_empty_i) begin
          pop_c   = 1'b1;
          err_d   = 1'b0;
          waddr_d = miss_addr_fifo_rdata_i[LINE_OFF_W +: IDX_W];
          tag_d   = {1'b1, miss_addr_fifo_rdata_i[ADDR_W-1 -: LINE_TAG_W]};
          state_d = FILL;
        end
      end
      FILL: begin
        if (hs_c) begin
          err_d = err_q | beat_err_c;
          if (last_beat_c) begin
            state_d = WRITE;
            wren_d  = !err_d;
            ferr_d  = err_d;
          end
        end
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      rready_q <= 1'b0;
      wren_q   <= 1'b0;
      ferr_q   <= 1'b0;
      waddr_q  <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      rready_q <= rready_d;
      wren_q   <= wren_d;
      ferr_q   <= ferr_d;
      waddr_q  <= waddr_d;
      tag_q    <= tag_d;
    end
  end

  cc_fill_deser #(
    .DATA_W     (DATA_W),
    .LINE_BYTES (LINE_BYTES)
  ) u_deser (
    .clk          (clk),
    .rst          (rst),
    .start_i      (pop_c),
    .start_slot_i (start_slot_c),
    .beat_vld_i   (hs_c),
    .beat_data_i  (mem_rdata_i),
    .cnt_o        (cnt_c),
    .line_o       (wdata_data_o),
    .cw_valid_o   (cw_valid_o),
    .cw_data_o    (cw_data_o)
  );

  assign miss_addr_fifo_rden_o = pop_c;
  assign mem_rready_o          = rready_q;
  assign wren_o                = wren_q;
  assign fill_err_o            = ferr_q;
  assign waddr_o               = waddr_q;
  assign wdata_tag_o           = tag_q;

endmodule
